// File: rtl/channel_acq_controller_async_nch_pkg.sv
// Shared definitions for channel_acq_controller_async_nch.
//   - one-hot state indices and the typed state enum
//   - bit-field layout of the second event word (status word)
//   - width and ceiling of the saturating dropped-trigger count
//   - pack_word1(): assembles the status word from its fields
package channel_acq_controller_async_nch_pkg;

  // Bit positions of each state in the one-hot 'state' output.
  localparam int unsigned ST_IDLE       = 0;
  localparam int unsigned ST_WAIT       = 1;
  localparam int unsigned ST_STORE_HDR  = 2;
  localparam int unsigned ST_STORE_STAT = 3;
  localparam int unsigned ST_READOUT    = 4;
  localparam int unsigned NUM_STATES    = 5;

  typedef enum logic [NUM_STATES-1:0] {
    StIdle      = 5'b00001 << ST_IDLE,
    StWait      = 5'b00001 << ST_WAIT,
    StStoreHdr  = 5'b00001 << ST_STORE_HDR,
    StStoreStat = 5'b00001 << ST_STORE_STAT,
    StReadout   = 5'b00001 << ST_READOUT
  } acq_state_e;

  // Status word layout: {timeout, dropped count, missing-channel mask}.
  localparam int unsigned TIMEOUT_BIT = 31;
  localparam int unsigned DROP_LSB    = 16;
  localparam int unsigned MISS_W      = DROP_LSB;

  // Saturating dropped-trigger count.
  localparam int unsigned         DROP_W   = 15;
  localparam logic [DROP_W-1:0]   DROP_MAX = '1;

  function automatic logic [31:0] pack_word1(input logic              timeout,
                                             input logic [DROP_W-1:0] drops,
                                             input logic [MISS_W-1:0] missing);
    logic [31:0] w;
    w                       = '0;
    w[TIMEOUT_BIT]          = timeout;
    w[DROP_LSB +: DROP_W]   = drops;
    w[MISS_W-1:0]           = missing;
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with synchronous clear and load.
// Priority: clear > load > step. Counting up stops at MAX; counting down
// (DOWN = 1) stops at zero.
//   clk, reset_n : clock, asynchronous active-low reset (count -> 0)
//   clear        : force count to 0
//   load         : force count to load_value
//   step         : advance one count toward the saturation limit
//   count        : current value
module sat_counter #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  MAX   = '1,
  parameter bit                DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (step) begin
      if (DOWN) begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end else begin
        if (count_q != MAX) count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/channel_acq_controller_async_nch.sv
// Asynchronous-mode acquisition controller for NUM_CHAN digitizer channels.
// A TTC trigger in IDLE snapshots the channel enables, waits for every enabled
// channel's done (or a timeout), then writes a two-word event record to the
// event FIFO under valid/ready and waits for the readout to finish. In IDLE,
// front-panel pulse triggers are forwarded to the channels with a holdoff.
//
//   clk, reset_n          : 40 MHz TTC clock, asynchronous active-low reset
//   chan_en               : channels taking part in acquisition
//   accept_pulse_triggers : forward front-panel triggers while idle
//   async_mode            : asynchronous mode select
//   readout_done          : readout finished (READOUT only)
//   ttc_trigger/_type/_num: TTC trigger strobe and its type/number
//   ttc_acq_ready         : high while idle
//   pulse_trigger         : front-panel trigger strobe
//   acq_dones             : per-channel done
//   acq_enable, acq_trig  : registered channel enables / triggers
//   fifo_ready/valid/data : event FIFO write handshake
//   dropped_trig_count    : TTC triggers ignored while busy (saturating)
//   state                 : one-hot state
module channel_acq_controller_async_nch
  import channel_acq_controller_async_nch_pkg::*;
#(
  parameter int unsigned NUM_CHAN      = 5,
  parameter int unsigned TRIG_TYPE_W   = 3,
  parameter int unsigned TRIG_NUM_W    = 24,
  parameter int unsigned DONE_TIMEOUT  = 65535,
  parameter int unsigned PULSE_HOLDOFF = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CHAN-1:0]    chan_en,
  input  logic                   accept_pulse_triggers,
  input  logic                   async_mode,
  input  logic                   readout_done,
  input  logic                   ttc_trigger,
  input  logic [TRIG_TYPE_W-1:0] ttc_trig_type,
  input  logic [TRIG_NUM_W-1:0]  ttc_trig_num,
  output logic                   ttc_acq_ready,
  input  logic                   pulse_trigger,
  input  logic [NUM_CHAN-1:0]    acq_dones,
  output logic [2*NUM_CHAN-1:0]  acq_enable,
  output logic [NUM_CHAN-1:0]    acq_trig,
  input  logic                   fifo_ready,
  output logic                   fifo_valid,
  output logic [31:0]            fifo_data,
  output logic [DROP_W-1:0]      dropped_trig_count,
  output logic [NUM_STATES-1:0]  state
);

  // Timeout counter only needs to reach DONE_TIMEOUT-1.
  localparam int unsigned TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (DONE_TIMEOUT > 0) ? TO_W'(DONE_TIMEOUT - 1) : '1;
  localparam int unsigned HO_W = (PULSE_HOLDOFF > 0) ? $clog2(PULSE_HOLDOFF + 1) : 1;

  acq_state_e state_q, state_d;

  logic [TRIG_TYPE_W-1:0] type_q;
  logic [TRIG_NUM_W-1:0]  num_q;
  logic [NUM_CHAN-1:0]    en_snap_q;
  logic [NUM_CHAN-1:0]    mask_q;
  logic                   timeout_q;
  logic [NUM_CHAN-1:0]    missing_q;
  logic [DROP_W-1:0]      drop_snap_q;
  logic [2*NUM_CHAN-1:0]  acq_enable_q;
  logic [NUM_CHAN-1:0]    acq_trig_q;

  logic [TO_W-1:0]        to_count;
  logic [HO_W-1:0]        holdoff_count;
  logic [DROP_W-1:0]      drop_count;

  logic                   idle, in_wait, in_hdr, in_stat;
  logic                   start_event, pulse_path, fwd_pulse, drop;
  logic                   hdr_accept, stat_accept;
  logic [NUM_CHAN-1:0]    dones_en;
  logic                   all_done, timed_out;
  logic [DROP_W-1:0]      drop_count_inc;

  assign idle    = (state_q == StIdle);
  assign in_wait = (state_q == StWait);
  assign in_hdr  = (state_q == StStoreHdr);
  assign in_stat = (state_q == StStoreStat);

  // TTC trigger wins over a coincident pulse in IDLE.
  assign start_event = idle & ttc_trigger & async_mode;
  assign pulse_path  = idle & ~start_event & accept_pulse_triggers & async_mode;
  assign fwd_pulse   = pulse_path & pulse_trigger & (holdoff_count == '0);

  assign drop        = ttc_trigger & ~idle;
  assign hdr_accept  = in_hdr & fifo_ready;
  assign stat_accept = in_stat & fifo_ready;

  assign dones_en  = acq_dones & en_snap_q;
  assign all_done  = ((mask_q | dones_en) == en_snap_q);
  assign timed_out = (DONE_TIMEOUT != 0) && (to_count == TO_LAST);

  // Count value after this edge, used to freeze the status word's drop field.
  assign drop_count_inc = (drop_count == DROP_MAX) ? DROP_MAX : drop_count + DROP_W'(drop);

  // Counters ------------------------------------------------------------------

  sat_counter #(
    .WIDTH (DROP_W),
    .MAX   (DROP_MAX),
    .DOWN  (1'b0)
  ) u_drop_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (stat_accept & ~drop),
    .load       (stat_accept & drop),   // a drop on the clearing edge still counts
    .load_value (DROP_W'(1)),
    .step       (drop),
    .count      (drop_count)
  );

  sat_counter #(
    .WIDTH (TO_W),
    .MAX   (TO_LAST),
    .DOWN  (1'b0)
  ) u_timeout_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_event),
    .load       (1'b0),
    .load_value ('0),
    .step       (in_wait),
    .count      (to_count)
  );

  sat_counter #(
    .WIDTH (HO_W),
    .MAX   ('1),
    .DOWN  (1'b1)
  ) u_holdoff_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (1'b0),
    .load       (fwd_pulse),
    .load_value (HO_W'(PULSE_HOLDOFF)),
    .step       (1'b1),
    .count      (holdoff_count)
  );

  // FSM -----------------------------------------------------------------------

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_event)           state_d = StWait;
      StWait:      if (all_done || timed_out) state_d = StStoreHdr;
      StStoreHdr:  if (fifo_ready)            state_d = StStoreStat;
      StStoreStat: if (fifo_ready)            state_d = StReadout;
      StReadout:   if (readout_done)          state_d = StIdle;
      default:                                state_d = StIdle;
    endcase
  end

  always_comb begin
    ttc_acq_ready = 1'b0;
    fifo_valid    = 1'b0;
    fifo_data     = '0;
    unique case (state_q)
      StIdle: ttc_acq_ready = 1'b1;
      StStoreHdr: begin
        fifo_valid = 1'b1;
        fifo_data  = 32'({type_q, num_q});
      end
      StStoreStat: begin
        fifo_valid = 1'b1;
        fifo_data  = pack_word1(timeout_q, drop_snap_q, MISS_W'(missing_q));
      end
      default: ;
    endcase
  end

  // Event latches -------------------------------------------------------------

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q      <= '0;
      num_q       <= '0;
      en_snap_q   <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
      missing_q   <= '0;
      drop_snap_q <= '0;
    end else begin
      if (start_event) begin
        type_q    <= ttc_trig_type;
        num_q     <= ttc_trig_num;
        en_snap_q <= chan_en;
        mask_q    <= '0;
      end else if (in_wait) begin
        mask_q <= mask_q | dones_en;
      end
      if (in_wait) begin
        if (all_done) begin
          timeout_q <= 1'b0;
          missing_q <= '0;
        end else if (timed_out) begin
          timeout_q <= 1'b1;
          missing_q <= en_snap_q & ~mask_q;
        end
      end
      // Freeze the drop field so word1 stays stable while it waits for ready.
      if (hdr_accept) drop_snap_q <= drop_count_inc;
    end
  end

  // Channel outputs -----------------------------------------------------------

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acq_enable_q <= '0;
      acq_trig_q   <= '0;
    end else begin
      acq_enable_q <= {(2*NUM_CHAN){pulse_path}};
      acq_trig_q   <= fwd_pulse ? chan_en : '0;
    end
  end

  assign acq_enable         = acq_enable_q;
  assign acq_trig           = acq_trig_q;
  assign dropped_trig_count = drop_count;
  assign state              = state_q;

endmodule

// File: tb/tb_channel_acq_controller_async_nch.sv
`timescale 1ns/1ps
module tb_channel_acq_controller_async_nch;

  localparam int unsigned NC = 5;
  localparam int unsigned PH = 3;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_WAIT = 5'b00010;
  localparam logic [4:0] S_HDR  = 5'b00100;
  localparam logic [4:0] S_STAT = 5'b01000;
  localparam logic [4:0] S_RO   = 5'b10000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC-1:0] chan_en = '0;
  logic          accept_pulse_triggers = 1'b0;
  logic          async_mode = 1'b0;
  logic          readout_done = 1'b0;
  logic          ttc_trigger = 1'b0;
  logic [2:0]    ttc_trig_type = '0;
  logic [23:0]   ttc_trig_num = '0;
  logic          ttc_acq_ready;
  logic          pulse_trigger = 1'b0;
  logic [NC-1:0] acq_dones = '0;
  logic [2*NC-1:0] acq_enable;
  logic [NC-1:0] acq_trig;
  logic          fifo_ready = 1'b0;
  logic          fifo_valid;
  logic [31:0]   fifo_data;
  logic [14:0]   dropped_trig_count;
  logic [4:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  channel_acq_controller_async_nch #(
    .NUM_CHAN      (NC),
    .TRIG_TYPE_W   (3),
    .TRIG_NUM_W    (24),
    .DONE_TIMEOUT  (8),
    .PULSE_HOLDOFF (PH)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .chan_en               (chan_en),
    .accept_pulse_triggers (accept_pulse_triggers),
    .async_mode            (async_mode),
    .readout_done          (readout_done),
    .ttc_trigger           (ttc_trigger),
    .ttc_trig_type         (ttc_trig_type),
    .ttc_trig_num          (ttc_trig_num),
    .ttc_acq_ready         (ttc_acq_ready),
    .pulse_trigger         (pulse_trigger),
    .acq_dones             (acq_dones),
    .acq_enable            (acq_enable),
    .acq_trig              (acq_trig),
    .fifo_ready            (fifo_ready),
    .fifo_valid            (fifo_valid),
    .fifo_data             (fifo_data),
    .dropped_trig_count    (dropped_trig_count),
    .state                 (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference event words built from the field definitions.
  function automatic logic [31:0] word0(input logic [2:0] t, input logic [23:0] n);
    return {5'b0, t, n};
  endfunction

  function automatic logic [31:0] word1(input bit to, input int drops, input logic [4:0] miss);
    logic [14:0] d;
    d = drops[14:0];
    return {to, d, 11'b0, miss};
  endfunction

  initial begin
    // ---------------- reset state
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_ready", 32'(ttc_acq_ready), 32'd1);
    chk("rst_valid", 32'(fifo_valid), 32'd0);
    chk("rst_data", fifo_data, 32'd0);
    chk("rst_enable", 32'(acq_enable), 32'd0);
    chk("rst_trig", 32'(acq_trig), 32'd0);
    chk("rst_drops", 32'(dropped_trig_count), 32'd0);

    // ---------------- trigger ignored without async_mode
    ttc_trigger = 1'b1;
    tick();
    chk("noasync_state", 32'(state), 32'(S_IDLE));
    chk("noasync_drops", 32'(dropped_trig_count), 32'd0);

    // ---------------- normal event
    async_mode = 1'b1; fifo_ready = 1'b1;
    chan_en = 5'b10101; ttc_trig_type = 3'd5; ttc_trig_num = 24'h00ABCD;
    tick();
    ttc_trigger = 1'b0;
    chk("norm_wait", 32'(state), 32'(S_WAIT));
    chk("norm_notready", 32'(ttc_acq_ready), 32'd0);
    acq_dones = 5'b00001; tick();
    acq_dones = 5'b00100; tick();
    chk("norm_still_wait", 32'(state), 32'(S_WAIT));
    acq_dones = 5'b10000; tick();
    acq_dones = '0;
    chk("norm_hdr_state", 32'(state), 32'(S_HDR));
    chk("norm_hdr_valid", 32'(fifo_valid), 32'd1);
    chk("norm_word0", fifo_data, 32'h0500ABCD);
    tick();
    chk("norm_stat_state", 32'(state), 32'(S_STAT));
    chk("norm_word1", fifo_data, 32'h00000000);
    tick();
    chk("norm_readout", 32'(state), 32'(S_RO));
    chk("norm_ro_valid", 32'(fifo_valid), 32'd0);
    tick();
    chk("norm_ro_hold", 32'(state), 32'(S_RO));
    readout_done = 1'b1; tick(); readout_done = 1'b0;
    chk("norm_idle", 32'(state), 32'(S_IDLE));

    // ---------------- done timeout
    chan_en = 5'b00011; ttc_trig_type = 3'd1; ttc_trig_num = 24'h000042;
    ttc_trigger = 1'b1; tick(); ttc_trigger = 1'b0;
    acq_dones = 5'b00001; tick(); acq_dones = '0;
    repeat (6) tick();
    chk("to_wait7", 32'(state), 32'(S_WAIT));
    tick();
    chk("to_hdr_at8", 32'(state), 32'(S_HDR));
    chk("to_word0", fifo_data, 32'h01000042);
    tick();
    chk("to_word1", fifo_data, 32'h80000002);
    tick();
    readout_done = 1'b1; tick(); readout_done = 1'b0;

    // ---------------- triggers dropped while busy
    chan_en = 5'b00001;
    ttc_trigger = 1'b1; tick();
    repeat (3) tick();
    ttc_trigger = 1'b0;
    chk("drop_live", 32'(dropped_trig_count), 32'd3);
    acq_dones = 5'b00001; tick(); acq_dones = '0;
    chk("drop_hdr", 32'(state), 32'(S_HDR));
    tick();
    chk("drop_word1", fifo_data, 32'h00030000);
    tick();
    chk("drop_cleared", 32'(dropped_trig_count), 32'd0);
    readout_done = 1'b1; tick(); readout_done = 1'b0;

    // ---------------- FIFO backpressure
    chan_en = 5'b00000; fifo_ready = 1'b0;
    ttc_trig_type = 3'd7; ttc_trig_num = 24'h123456;
    ttc_trigger = 1'b1; tick(); ttc_trigger = 1'b0;
    tick();  // empty snapshot leaves WAIT after one cycle
    for (int i = 0; i < 4; i++) begin
      chk("bp_hdr_state", 32'(state), 32'(S_HDR));
      chk("bp_valid", 32'(fifo_valid), 32'd1);
      chk("bp_word0", fifo_data, 32'h07123456);
      tick();
    end
    chk("bp_word0_last", fifo_data, 32'h07123456);
    fifo_ready = 1'b1; tick(); fifo_ready = 1'b0;
    chk("bp_word1", fifo_data, 32'h00000000);
    chk("bp_stat", 32'(state), 32'(S_STAT));
    tick();
    chk("bp_stat_hold", 32'(state), 32'(S_STAT));
    fifo_ready = 1'b1; tick();
    chk("bp_ro", 32'(state), 32'(S_RO));
    readout_done = 1'b1; tick(); readout_done = 1'b0;

    // ---------------- pulse holdoff
    begin
      int last;
      bit fwd;
      last = -100;
      chan_en = 5'b10110; accept_pulse_triggers = 1'b1; pulse_trigger = 1'b1;
      for (int k = 0; k < 6; k++) begin
        fwd = (k - last) > int'(PH);
        if (fwd) last = k;
        tick();
        chk("ho_trig", 32'(acq_trig), fwd ? 32'(5'b10110) : 32'd0);
        chk("ho_enable", 32'(acq_enable), 32'h3FF);
      end
      pulse_trigger = 1'b0;
      repeat (4) tick();
      chk("ho_quiet", 32'(acq_trig), 32'd0);
    end

    // ---------------- pulse coincident with TTC trigger
    ttc_trigger = 1'b1; pulse_trigger = 1'b1; tick();
    ttc_trigger = 1'b0; pulse_trigger = 1'b0; accept_pulse_triggers = 1'b0;
    chk("coll_trig", 32'(acq_trig), 32'd0);
    chk("coll_enable", 32'(acq_enable), 32'd0);
    chk("coll_state", 32'(state), 32'(S_WAIT));
    chk("coll_drops", 32'(dropped_trig_count), 32'd0);
    acq_dones = 5'b10110; async_mode = 1'b0; tick(); acq_dones = '0;
    chk("coll_noabort", 32'(state), 32'(S_HDR));
    tick(); tick();
    readout_done = 1'b1; tick(); readout_done = 1'b0;
    async_mode = 1'b1;
    chk("coll_idle", 32'(state), 32'(S_IDLE));

    // ---------------- randomized events against the reference model
    accept_pulse_triggers = 1'b0;
    for (int e = 0; e < 25; e++) begin
      logic [4:0]  en, miss, dn;
      logic [2:0]  t;
      logic [23:0] n;
      int          d[NC];
      int          c, wlen, drops, stalls;
      bit          to;
      en = 5'($urandom); t = 3'($urandom); n = 24'($urandom);
      for (int i = 0; i < NC; i++) begin
        d[i] = $urandom_range(0, 9);
        if (d[i] > 6) d[i] = 99;  // never arrives
      end
      c = -1;
      for (int i = 0; i < NC; i++) if (en[i] && d[i] > c) c = d[i];
      miss = '0; to = 1'b0;
      if (c < 0) wlen = 1;
      else if (c <= 6) wlen = c + 1;
      else begin
        wlen = 8; to = 1'b1;
        for (int i = 0; i < NC; i++) if (en[i] && d[i] == 99) miss[i] = 1'b1;
      end

      chan_en = en; ttc_trig_type = t; ttc_trig_num = n; fifo_ready = 1'b0;
      ttc_trigger = 1'b1; tick();
      chan_en = 5'($urandom); ttc_trig_type = 3'($urandom); ttc_trig_num = 24'($urandom);
      drops = 0;
      for (int k = 0; k < wlen; k++) begin
        ttc_trigger = 1'($urandom);
        if (ttc_trigger) drops++;
        dn = '0;
        for (int i = 0; i < NC; i++) if (d[i] == k) dn[i] = 1'b1;
        acq_dones = dn;
        tick();
        if (k < wlen - 1) chk("rnd_wait", 32'(state), 32'(S_WAIT));
      end
      ttc_trigger = 1'b0; acq_dones = '0;
      chk("rnd_hdr", 32'(state), 32'(S_HDR));
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) begin
        chk("rnd_w0_stall", fifo_data, word0(t, n));
        tick();
      end
      chk("rnd_word0", fifo_data, word0(t, n));
      fifo_ready = 1'b1; tick(); fifo_ready = 1'b0;
      chk("rnd_stat", 32'(state), 32'(S_STAT));
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) begin
        chk("rnd_w1_stall", fifo_data, word1(to, drops, miss));
        tick();
      end
      chk("rnd_word1", fifo_data, word1(to, drops, miss));
      fifo_ready = 1'b1; tick(); fifo_ready = 1'b0;
      chk("rnd_ro", 32'(state), 32'(S_RO));
      chk("rnd_drops_clr", 32'(dropped_trig_count), 32'd0);
      repeat ($urandom_range(0, 2)) tick();
      readout_done = 1'b1; tick(); readout_done = 1'b0;
      chk("rnd_idle", 32'(state), 32'(S_IDLE));
    end

    // ---------------- asynchronous reset during STORE_STAT
    chan_en = 5'b00001; fifo_ready = 1'b0;
    ttc_trigger = 1'b1; tick();
    acq_dones = 5'b00001; tick();  // drop and completion in the same cycle
    ttc_trigger = 1'b0; acq_dones = '0;
    fifo_ready = 1'b1; tick(); fifo_ready = 1'b0;
    tick();
    chk("mid_stat", 32'(state), 32'(S_STAT));
    chk("mid_drops", 32'(dropped_trig_count), 32'd1);
    chk("mid_valid", 32'(fifo_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(fifo_valid), 32'd0);
    chk("arst_state", 32'(state), 32'(S_IDLE));
    chk("arst_drops", 32'(dropped_trig_count), 32'd0);
    chk("arst_ready", 32'(ttc_acq_ready), 32'd1);
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
